// File: rtl/mac_accumulator.sv
// mac_accumulator
//   Accumulate stage behind the 16x16 multiplier. Sums a burst of unsigned
//   products into an ACC_W-bit accumulator and presents the result with a
//   valid/ready handshake.
//
// Parameters:
//   PROD_W  product width (multiplier output)
//   ACC_W   accumulator width, ACC_W >= PROD_W
//   COUNT   maximum products per burst, COUNT >= 1
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_prod valid
//   in_ready   product accepted this cycle (state-only, low while holding)
//   in_prod    unsigned product
//   in_last    final product of a burst (qualified by in_valid)
//   out_valid  result valid
//   out_ready  downstream accepts result
//   out_acc    accumulated sum
//   out_count  number of products summed
//   out_ovf    sticky carry-out-of-ACC_W flag for the burst
//
// Configuration:
//   MAC_SAT_EN  defined: accumulator clamps to all-ones on carry out.
//               undefined: accumulator wraps modulo 2^ACC_W.
//   out_ovf is sticky in both builds.

module mac_accumulator #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int COUNT  = 8,
    localparam int CW    = $clog2(COUNT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CW-1:0]     out_count,
    output logic              out_ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [ACC_W-1:0] acc, acc_nx;
    logic [CW-1:0]    count, count_nx;
    logic             ovf, ovf_nx;

    logic [ACC_W:0]   sum;
    logic [CW-1:0]    count_inc;
    logic             accept;
    logic             burst_end;

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign out_acc   = acc;
    assign out_count = count;
    assign out_ovf   = ovf;

    assign accept    = in_valid && in_ready;
    assign sum       = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
    assign count_inc = count + CW'(1);
    // Burst ends on an explicit last or when the beat fills the burst.
    assign burst_end = in_last || (count_inc == CW'(COUNT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            acc   <= acc_nx;
            count <= count_nx;
            ovf   <= ovf_nx;
        end
    end

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        count_nx = count;
        ovf_nx   = ovf;
        case (state)
            IDLE, ACCUM: begin
                if (accept) begin
`ifdef MAC_SAT_EN
                    // Once clamped, any further nonzero product carries
                    // again, so the accumulator stays at all-ones.
                    acc_nx = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
                    acc_nx = sum[ACC_W-1:0];
`endif
                    count_nx = count_inc;
                    ovf_nx   = ovf | sum[ACC_W];
                    state_nx = burst_end ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nx = IDLE;
                    acc_nx   = '0;
                    count_nx = '0;
                    ovf_nx   = 1'b0;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Sequential accumulate stage that sits directly downstream of the 16x16 Wallace-tree multiplier. It consumes the multiplier's 32-bit unsigned product under a valid/ready handshake and sums a burst of products into a wide accumulator. It then presents the dot-product result with a valid/ready handshake to the next stage.

## Interface

Parameters:
- PROD_W, 32, product width; matches multiplier output z.
- ACC_W, 40, accumulator width; ACC_W >= PROD_W.
- COUNT, 8, maximum products per burst; COUNT >= 1.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_prod is valid.
- in_ready  output  1  block accepts a product this cycle.
- in_prod  input  PROD_W  unsigned product from the multiplier.
- in_last  input  1  marks the final product of a burst; qualified by in_valid.
- out_valid  output  1  out_acc and out_count are valid.
- out_ready  input  1  downstream accepts the result.
- out_acc  output  ACC_W  accumulated sum.
- out_count  output  $clog2(COUNT+1)  number of products summed.
- out_ovf  output  1  sticky flag: the accumulator exceeded 2^ACC_W-1 during this burst.

## Operation

- States:
  - IDLE: acc = 0, count = 0.
  - ACCUM: at least one beat accepted.
  - HOLD: result presented.
- Beat accepted when in_valid && in_ready.
- in_ready = 1 in IDLE and ACCUM, 0 in HOLD.
- On an accepted beat:
  - acc <= acc + zero-extended in_prod.
  - count <= count + 1.
  - ovf is set if the sum carries out of ACC_W bits.
- Transitions:
  - IDLE -> ACCUM on an accepted beat without a burst end.
  - IDLE or ACCUM -> HOLD on an accepted beat with in_last = 1, or when the accepted beat makes count == COUNT. A burst end in IDLE means a single-beat burst.
  - HOLD -> IDLE on out_valid && out_ready; acc, count and ovf clear on that edge.
- out_valid = 1 exactly in HOLD.
- out_acc, out_count and out_ovf are held stable in HOLD until the handshake completes.
- in_last with in_valid = 0 is ignored.
- in_prod, in_valid and in_last are don't-care in HOLD.
- Reset (asynchronous, any state, including mid-burst): state IDLE, acc 0, count 0, ovf 0; the partial burst is discarded.
- Reset values of outputs: in_ready 1, out_valid 0, out_acc 0, out_count 0, out_ovf 0.

## Timing

- The accepted beat is summed on the same clock edge.
- The final beat's edge also enters HOLD, so out_valid rises 1 cycle after the last accepted beat.
- Throughput: one product per cycle within a burst.
- Each burst costs 1 bubble cycle minimum: a HOLD cycle in which out_ready = 1 is accepted.
- in_ready returns to 1 the cycle after the output handshake.
- No combinational path from out_ready to in_ready; in_ready depends only on state.
- out_acc, out_count and out_ovf are driven directly from registers.

## Configuration

- MAC_SAT_EN defined:
  - On a carry out of ACC_W bits, acc clamps to 2^ACC_W-1 and stays there for the rest of the burst.
  - out_ovf = 1.
- MAC_SAT_EN undefined:
  - acc wraps modulo 2^ACC_W.
  - out_ovf still sets sticky on any carry out.

## Test plan

- Full burst: 8 beats of in_prod = 0xFFFE0001 (0xFFFF*0xFFFF), in_last = 0, out_ready = 1 -> out_valid rises 1 cycle after beat 8, with out_acc = 0x7FFF00008, out_count = 8, out_ovf = 0, and in_ready = 0 for exactly 1 cycle.
- Short burst: products 0x00000001, 0x01002001 (0x1001*0x1001), then 0x00000001 with in_last = 1 -> out_acc = 0x01002003, out_count = 3.
- Backpressure: after a burst, hold out_ready = 0 for 5 cycles with in_valid = 1 -> out_valid and outputs stable, in_ready = 0, no beats accepted; out_ready = 1 -> IDLE next cycle with in_ready = 1.
- Overflow with ACC_W = 34: 8 x 0xFFFE0001 -> with MAC_SAT_EN, out_acc = 0x3FFFFFFFF and out_ovf = 1; without it, out_acc = 0x3FFF00008 and out_ovf = 1.
- Reset mid-burst: accept 3 beats of 0x00000005, assert rst_n = 0 asynchronously between edges -> outputs immediately at reset values; the next burst of 2 x 0x00000002 with in_last gives out_acc = 4, out_count = 2.
- Gapped input: a 4-beat burst of 0x00000010 with in_valid low on alternate cycles -> out_acc = 0x40, out_count = 4, and no beat is lost or double-counted.
